// File: rtl/wb_pkg.sv
// Shared constants and entry record for the writeback queue in front of the 8x16 register file.
package wb_pkg;
  localparam int N     = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int PW    = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] dst;
    logic [N-1:0]  data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-first search of the pending writeback entries for one register read port.
module wb_fwd_match
  import wb_pkg::*;
(
  input  wb_entry_t        entries [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0]    head,
  input  logic [CW-1:0]    count,
  input  logic [AW-1:0]    sel,
  output logic             hit,
  output logic [N-1:0]     data
);

  // Index gi is age order: 0 is the oldest pending entry (at head).
  logic [DEPTH-1:0] match_age;
  logic [N-1:0]     data_age [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [PW-1:0] slot;
    assign slot          = head + PW'(gi);
    assign match_age[gi] = (CW'(gi) < count) && valid[slot] && (entries[slot].dst == sel);
    assign data_age[gi]  = entries[slot].data;
  end

  // Later (younger) matches overwrite earlier ones, so the entry nearest tail wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_age[i]) begin
        hit  = 1'b1;
        data = data_age[i];
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// In-order writeback FIFO draining onto the register file write port, with read-port forwarding.
module wb_queue
  import wb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [AW-1:0] enq_reg,
  input  logic [N-1:0]  enq_data,
  input  logic          rf_stall,
  output logic          rf_wr_en,
  output logic [AW-1:0] rf_write_sel,
  output logic [N-1:0]  rf_data_in,
  input  logic [AW-1:0] fwd1_sel,
  output logic          fwd1_hit,
  output logic [N-1:0]  fwd1_data,
  input  logic [AW-1:0] fwd2_sel,
  output logic          fwd2_hit,
  output logic [N-1:0]  fwd2_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err
);

  wb_entry_t        entries_reg [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;
  logic             err_reg;
  logic             do_enq;
  logic             do_drain;

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign enq_ready = !full;
  assign count     = count_reg;
  assign err       = err_reg;

  // A full queue refuses requests even when the head drains this cycle.
  assign do_enq   = enq_valid && enq_ready;
  assign do_drain = rf_wr_en;

  assign rf_wr_en     = !empty && !rf_stall;
  assign rf_write_sel = empty ? '0 : entries_reg[head_reg].dst;
  assign rf_data_in   = empty ? '0 : entries_reg[head_reg].data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (do_enq)   tail_reg <= tail_reg + 1'b1;
      if (do_drain) head_reg <= head_reg + 1'b1;
      case ({do_enq, do_drain})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      err_reg <= enq_valid && !enq_ready;
    end
  end

  // head == tail with both enqueue and drain cannot occur: that needs full or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_enq && (tail_reg == PW'(i)))
          valid_reg[i] <= 1'b1;
        else if (do_drain && (head_reg == PW'(i)))
          valid_reg[i] <= 1'b0;
      end
    end
  end

  // Payload needs no reset; valid bits and count gate every use of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_enq && (tail_reg == PW'(i)))
        entries_reg[i] <= '{dst: enq_reg, data: enq_data};
    end
  end

  wb_fwd_match u_fwd1 (
    .entries (entries_reg),
    .valid   (valid_reg),
    .head    (head_reg),
    .count   (count_reg),
    .sel     (fwd1_sel),
    .hit     (fwd1_hit),
    .data    (fwd1_data)
  );

  wb_fwd_match u_fwd2 (
    .entries (entries_reg),
    .valid   (valid_reg),
    .head    (head_reg),
    .count   (count_reg),
    .sel     (fwd2_sel),
    .hit     (fwd2_hit),
    .data    (fwd2_data)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: reset, single write, fill/overflow, drain order, simultaneous, wrap.
module tb_wb_queue;
  import wb_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enq_valid;
  logic          enq_ready;
  logic [AW-1:0] enq_reg;
  logic [N-1:0]  enq_data;
  logic          rf_stall;
  logic          rf_wr_en;
  logic [AW-1:0] rf_write_sel;
  logic [N-1:0]  rf_data_in;
  logic [AW-1:0] fwd1_sel;
  logic          fwd1_hit;
  logic [N-1:0]  fwd1_data;
  logic [AW-1:0] fwd2_sel;
  logic          fwd2_hit;
  logic [N-1:0]  fwd2_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          err;

  int errors = 0;
  int checks = 0;
  logic [AW+N-1:0] commit_log [$];

  always #5 clk = ~clk;

  wb_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enq_valid    (enq_valid),
    .enq_ready    (enq_ready),
    .enq_reg      (enq_reg),
    .enq_data     (enq_data),
    .rf_stall     (rf_stall),
    .rf_wr_en     (rf_wr_en),
    .rf_write_sel (rf_write_sel),
    .rf_data_in   (rf_data_in),
    .fwd1_sel     (fwd1_sel),
    .fwd1_hit     (fwd1_hit),
    .fwd1_data    (fwd1_data),
    .fwd2_sel     (fwd2_sel),
    .fwd2_hit     (fwd2_hit),
    .fwd2_data    (fwd2_data),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .err          (err)
  );

  // Every register-file write seen at a clock edge, in order.
  always @(posedge clk) begin
    if (rst_n && rf_wr_en)
      commit_log.push_back({rf_write_sel, rf_data_in});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic enq(input logic [AW-1:0] r, input logic [N-1:0] d);
    enq_valid = 1'b1;
    enq_reg   = r;
    enq_data  = d;
    tick();
    enq_valid = 1'b0;
  endtask

  logic [AW-1:0] exp_sel [4];
  logic [N-1:0]  exp_dat [4];
  logic [N-1:0]  exp_f1  [4];
  logic          exp_h1  [4];
  int            wi;
  int            cyc;
  logic [AW+N-1:0] item;

  initial begin
    rst_n = 1'b0; enq_valid = 1'b0; enq_reg = '0; enq_data = '0;
    rf_stall = 1'b0; fwd1_sel = '0; fwd2_sel = '0;
    #3;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_err", err, 0);
    chk("rst_fwd1_data", fwd1_data, 0);
    tick(); tick();
    #1 rst_n = 1'b1;
    tick();

    // Reset mid-operation drops pending entries
    rf_stall = 1'b1;
    enq(3'd1, 16'h1111); enq(3'd2, 16'h2222); enq(3'd3, 16'h3333);
    fwd1_sel = 3'd2;
    #1;
    chk("pre_rst_count", count, 3);
    chk("pre_rst_fwd1_hit", fwd1_hit, 1);
    rst_n = 1'b0; rf_stall = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_empty", empty, 1);
    chk("async_rst_wr_en", rf_wr_en, 0);
    chk("async_rst_fwd1_hit", fwd1_hit, 0);
    tick();
    #1 rst_n = 1'b1;
    commit_log.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_write", rf_wr_en, 0);
    end
    chk("post_rst_log", commit_log.size(), 0);

    // Single write
    enq(3'd3, 16'h1234);
    fwd1_sel = 3'd3;
    #1;
    chk("single_wr_en", rf_wr_en, 1);
    chk("single_sel", rf_write_sel, 3);
    chk("single_data", rf_data_in, 16'h1234);
    chk("single_fwd1_hit", fwd1_hit, 1);
    chk("single_fwd1_data", fwd1_data, 16'h1234);
    tick();
    chk("single_empty", empty, 1);
    chk("single_wr_en_off", rf_wr_en, 0);
    chk("single_fwd1_off", fwd1_hit, 0);

    // Fill under stall, then overflow
    rf_stall = 1'b1;
    enq(3'd1, 16'h0001); enq(3'd2, 16'h0002); enq(3'd1, 16'h00AA); enq(3'd5, 16'hBEEF);
    fwd1_sel = 3'd1; fwd2_sel = 3'd6;
    #1;
    chk("fill_full", full, 1);
    chk("fill_ready", enq_ready, 0);
    chk("fill_count", count, 4);
    chk("fill_stall_wr_en", rf_wr_en, 0);
    chk("fill_fwd1_data", fwd1_data, 16'h00AA);
    chk("fill_fwd2_hit", fwd2_hit, 0);
    chk("fill_fwd2_data", fwd2_data, 0);
    chk("fill_err_idle", err, 0);
    enq(3'd6, 16'h6666);
    chk("ovf_err", err, 1);
    chk("ovf_count", count, 4);
    chk("ovf_fwd2_hit", fwd2_hit, 0);
    tick();
    chk("ovf_err_clear", err, 0);

    // Drain in order, forwarding on R1
    exp_sel = '{3'd1, 3'd2, 3'd1, 3'd5};
    exp_dat = '{16'h0001, 16'h0002, 16'h00AA, 16'hBEEF};
    exp_f1  = '{16'h00AA, 16'h00AA, 16'h00AA, 16'h0000};
    exp_h1  = '{1'b1, 1'b1, 1'b1, 1'b0};
    rf_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_wr_en", rf_wr_en, 1);
      chk("drain_sel", rf_write_sel, exp_sel[i]);
      chk("drain_data", rf_data_in, exp_dat[i]);
      chk("drain_count", count, 4 - i);
      chk("drain_fwd1_hit", fwd1_hit, exp_h1[i]);
      chk("drain_fwd1_data", fwd1_data, exp_f1[i]);
      tick();
    end
    chk("drain_empty", empty, 1);

    // Simultaneous enqueue and drain at count 2
    rf_stall = 1'b1;
    enq(3'd4, 16'h0044); enq(3'd7, 16'h0077);
    rf_stall = 1'b0;
    exp_sel = '{3'd4, 3'd7, 3'd0, 3'd1};
    exp_dat = '{16'h0044, 16'h0077, 16'h0A00, 16'h0A01};
    for (int i = 0; i < 3; i++) begin
      enq_valid = 1'b1; enq_reg = AW'(i); enq_data = 16'h0A00 + 16'(i);
      #1;
      chk("simul_count", count, 2);
      chk("simul_ready", enq_ready, 1);
      chk("simul_sel", rf_write_sel, exp_sel[i]);
      chk("simul_data", rf_data_in, exp_dat[i]);
      tick();
    end
    enq_valid = 1'b0;
    #1;
    chk("simul_count_after", count, 2);
    chk("simul_err", err, 0);
    chk("simul_sel3", rf_write_sel, 3'd1);
    chk("simul_data3", rf_data_in, 16'h0A01);
    tick();
    chk("simul_sel4", rf_write_sel, 3'd2);
    chk("simul_data4", rf_data_in, 16'h0A02);
    tick();
    chk("simul_empty", empty, 1);

    // Wrap: ten requests with random stall
    commit_log.delete();
    wi = 0; cyc = 0;
    while ((wi < 10 || !empty) && cyc < 200) begin
      rf_stall = (wi < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (wi < 10) begin
        enq_reg = AW'(wi % 8); enq_data = 16'h0100 + 16'(wi);
        #1;
        enq_valid = enq_ready;
        if (enq_ready) wi++;
      end
      tick();
      enq_valid = 1'b0;
      cyc++;
    end
    chk("wrap_timeout", (cyc < 200), 1);
    chk("wrap_commits", commit_log.size(), 10);
    for (int i = 0; i < 10; i++) begin
      item = (i < commit_log.size()) ? commit_log[i] : '0;
      chk("wrap_entry", item, {AW'(i % 8), 16'h0100 + 16'(i)});
    end
    chk("wrap_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-side companion to the 8x16 register file. Collects writeback requests (destination register and data) from the pipeline into a small in-order FIFO.
- Drains one entry per cycle onto the register file's single write port (wr_en, write select, data_in).
- Forwards pending, not-yet-committed values to both read ports so readers never see stale register contents.

Parameters:
- N, 16, data width; matches register width.
- AW, 3, register select width (8 registers).
- DEPTH, 4, queue entries; power of two.
- CW, 3, count width; holds 0..DEPTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- enq_valid  in  1  writeback request present.
- enq_ready  out  1  queue can accept; equals !full.
- enq_reg  in  AW  destination register.
- enq_data  in  N  writeback data.
- rf_stall  in  1  register file write port unavailable this cycle.
- rf_wr_en  out  1  to register file wr_en.
- rf_write_sel  out  AW  to register file write select.
- rf_data_in  out  N  to register file data_in.
- fwd1_sel  in  AW  read port 1 select, same value as sent to the register file.
- fwd1_hit  out  1  a pending entry matches fwd1_sel.
- fwd1_data  out  N  youngest matching pending data; 0 when no hit.
- fwd2_sel, fwd2_hit, fwd2_data: same as port 1, for read port 2.
- count  out  CW  occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- err  out  1  one-cycle registered pulse: enq_valid while !enq_ready; the request is dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - head, tail, count = 0; all entry valid bits cleared; err = 0.
  - Therefore empty = 1, full = 0, rf_wr_en = 0, fwd hits = 0, fwd data = 0.
  - Reset mid-operation discards all pending entries; none are written to the register file.
- Storage: DEPTH-entry circular buffer of {reg, data}. head = oldest entry, tail = next free slot. Pointers are log2(DEPTH) bits and wrap naturally.
- Enqueue: at the edge where enq_valid && enq_ready, store at tail and advance tail.
- Drain (combinational outputs):
  - rf_wr_en = !empty && !rf_stall.
  - rf_write_sel and rf_data_in = entry at head.
  - rf_write_sel and rf_data_in are 0 when empty.
  - At an edge with rf_wr_en = 1, head advances.
- Latency: a request enqueued at edge k drives rf_wr_en in cycle k..k+1 and commits at edge k+1, when not stalled and no older entries are pending.
- Ordering: strictly FIFO. Multiple entries for the same register commit oldest-first, so the last write wins in the register file.
- Count update:
  - +1 on enqueue only, -1 on drain only.
  - Unchanged on simultaneous enqueue and drain, or when neither occurs.
- Full: enq_ready = 0 even if a drain occurs in the same cycle; no same-cycle pass-through.
- Empty: no drain; rf_stall has no effect.
- Forwarding (combinational, per port):
  - Searches all valid entries, including the head entry being written this cycle (the register file read returns the old value until the edge).
  - The youngest match, nearest tail, wins.
  - enq_data in the current cycle is not forwarded.
- err: registered. Set for one cycle after any edge with enq_valid && !enq_ready; otherwise 0.

Decomposition:
- Shared package wb_pkg: N, AW, DEPTH, CW constants; entry record type {reg, data}.
- One sub-module, wb_fwd_match: inputs are the entry array, valid bits, head, count and sel; outputs hit and data. It performs the youngest-first search and is instantiated twice, once per read port.

Test Plan:
- Reset: enqueue 3 entries, stall=1, pull rst_n low mid-cycle -> count=0, empty=1, rf_wr_en=0, fwd1_hit=0 immediately (asynchronous); after release, no writes ever appear.
- Single write: enqueue R3=0x1234, stall=0 -> next cycle rf_wr_en=1, rf_write_sel=3, rf_data_in=0x1234; with fwd1_sel=3 that cycle: fwd1_hit=1, fwd1_data=0x1234; following cycle empty=1.
- Fill under stall: stall=1, enqueue R1=0x0001, R2=0x0002, R1=0x00AA, R5=0xBEEF -> full=1, enq_ready=0; 5th enqueue R6=0x6666 -> err=1 for one cycle, count stays 4.
  - Forwarding checks: fwd1_sel=1 -> 0x00AA; fwd2_sel=6 -> hit=0, data=0.
- Drain order: release stall -> writes R1/0x0001, R2/0x0002, R1/0x00AA, R5/0xBEEF on consecutive cycles; count 4,3,2,1,0.
  - Forwarding on R1: 0x00AA until the third write commits, then hit=0.
- Simultaneous: with count=2, stall=0, enqueue every cycle for 3 cycles -> count holds 2; no err; data committed in enqueue order.
- Wrap: 10 back-to-back enqueues R(i mod 8)=0x0100+i with random rf_stall -> all 10 committed in order with correct data; head and tail wrap at least twice; no loss or duplication.
